// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_pkg
//  Description : Shared widths, ALU opcodes, error byte and one-hot sequencer
//                state encoding for the UART/ALU command path.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_pkg;

    localparam int c_nb_data  = 8;
    localparam int c_nb_op    = 6;
    localparam int c_nb_state = 6;

    localparam logic [c_nb_op-1:0] c_op_add = 6'b100000;
    localparam logic [c_nb_op-1:0] c_op_sub = 6'b100010;
    localparam logic [c_nb_op-1:0] c_op_and = 6'b100100;
    localparam logic [c_nb_op-1:0] c_op_or  = 6'b100101;
    localparam logic [c_nb_op-1:0] c_op_xor = 6'b100110;
    localparam logic [c_nb_op-1:0] c_op_nor = 6'b100111;
    localparam logic [c_nb_op-1:0] c_op_sra = 6'b000011;
    localparam logic [c_nb_op-1:0] c_op_srl = 6'b000010;

    localparam logic [c_nb_data-1:0] c_err_byte = 8'hFF;

    localparam logic [c_nb_state-1:0] c_st_idle    = 6'b000001;
    localparam logic [c_nb_state-1:0] c_st_get_b   = 6'b000010;
    localparam logic [c_nb_state-1:0] c_st_get_op  = 6'b000100;
    localparam logic [c_nb_state-1:0] c_st_exec    = 6'b001000;
    localparam logic [c_nb_state-1:0] c_st_send    = 6'b010000;
    localparam logic [c_nb_state-1:0] c_st_wait_tx = 6'b100000;

    function automatic logic is_legal_op(input logic [c_nb_op-1:0] op);
        case (op)
            c_op_add, c_op_sub, c_op_and, c_op_or,
            c_op_xor, c_op_nor, c_op_sra, c_op_srl: return 1'b1;
            default:                                return 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
//  Module      : sat_counter
//  Description : Event counter that sticks at its all-ones value.
//  Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int NB_CNT = 8
) (
    input  logic              clk,
    input  logic              i_rst,
    input  logic              i_inc,
    output logic [NB_CNT-1:0] o_cnt
);

    logic [NB_CNT-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_inc && (r_cnt != {NB_CNT{1'b1}})) begin
            r_cnt <= r_cnt + NB_CNT'(1);
        end
    end

    assign o_cnt = r_cnt;

endmodule
`default_nettype wire

// File: rtl/uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : uart_alu_sequencer
//  Description : Collects A/B/opcode frames from UART_RX, strobes the ALU and
//                returns one result byte through UART_TX.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_sequencer
    import alu_pkg::*;
#(
    parameter int                 NB_DATA     = c_nb_data,
    parameter int                 NB_OP       = c_nb_op,
    parameter int                 NB_TOUT     = 20,
    parameter int                 TIMEOUT_CYC = 1000000,
    parameter int                 NB_CNT      = 8,
    parameter logic [NB_DATA-1:0] ERR_BYTE    = c_err_byte
) (
    input  logic               clk,
    input  logic               i_rst,
    input  logic [NB_DATA-1:0] i_rx_data,
    input  logic               i_rx_done,
    input  logic               i_tx_done,
    output logic               o_tx_start,
    output logic [NB_DATA-1:0] o_tx_data,
    output logic [NB_DATA-1:0] o_datoA,
    output logic [NB_DATA-1:0] o_datoB,
    output logic [NB_OP-1:0]   o_operation,
    output logic               o_valid,
    input  logic [NB_DATA-1:0] i_result,
    output logic               o_busy,
    output logic [NB_CNT-1:0]  o_err_cnt,
    output logic [NB_CNT-1:0]  o_tout_cnt,
    output logic [NB_CNT-1:0]  o_drop_cnt
);

    localparam logic [NB_TOUT-1:0] c_tout_last = NB_TOUT'(TIMEOUT_CYC - 1);

    logic [c_nb_state-1:0] r_state;
    logic [c_nb_state-1:0] w_state_nxt;
    logic [NB_TOUT-1:0]    r_timer;
    logic [NB_TOUT-1:0]    w_timer_nxt;
    logic [NB_DATA-1:0]    r_dato_a;
    logic [NB_DATA-1:0]    r_dato_b;
    logic [NB_OP-1:0]      r_operation;
    logic [NB_DATA-1:0]    r_tx_data;
    logic                  r_valid;
    logic                  r_tx_start;
    logic                  r_busy;

    logic w_tout_hit;
    logic w_op_legal;
    logic w_ld_a;
    logic w_ld_b;
    logic w_ld_op;
    logic w_ld_err;
    logic w_ld_res;
    logic w_err_inc;
    logic w_tout_inc;
    logic w_drop_inc;

    assign w_tout_hit = (r_timer == c_tout_last);
    assign w_op_legal = is_legal_op(c_nb_op'(i_rx_data[NB_OP-1:0]));

    // A progress event always beats an expiring timer in the same cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_timer_nxt = '0;
        w_ld_a      = 1'b0;
        w_ld_b      = 1'b0;
        w_ld_op     = 1'b0;
        w_ld_err    = 1'b0;
        w_ld_res    = 1'b0;
        w_err_inc   = 1'b0;
        w_tout_inc  = 1'b0;
        w_drop_inc  = 1'b0;
        case (r_state)
            c_st_idle: begin
                if (i_rx_done) begin
                    w_ld_a      = 1'b1;
                    w_state_nxt = c_st_get_b;
                end
            end
            c_st_get_b: begin
                if (i_rx_done) begin
                    w_ld_b      = 1'b1;
                    w_state_nxt = c_st_get_op;
                end else if (w_tout_hit) begin
                    w_tout_inc  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_timer_nxt = r_timer + NB_TOUT'(1);
                end
            end
            c_st_get_op: begin
                if (i_rx_done) begin
                    w_ld_op = 1'b1;
                    if (w_op_legal) begin
                        w_state_nxt = c_st_exec;
                    end else begin
                        w_ld_err    = 1'b1;
                        w_err_inc   = 1'b1;
                        w_state_nxt = c_st_send;
                    end
                end else if (w_tout_hit) begin
                    w_tout_inc  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_timer_nxt = r_timer + NB_TOUT'(1);
                end
            end
            c_st_exec: begin
                w_drop_inc  = i_rx_done;
                w_ld_res    = 1'b1;
                w_state_nxt = c_st_send;
            end
            c_st_send: begin
                w_drop_inc  = i_rx_done;
                w_state_nxt = c_st_wait_tx;
            end
            c_st_wait_tx: begin
                w_drop_inc = i_rx_done;
                if (i_tx_done) begin
                    w_state_nxt = c_st_idle;
                end else if (w_tout_hit) begin
                    w_tout_inc  = 1'b1;
                    w_state_nxt = c_st_idle;
                end else begin
                    w_timer_nxt = r_timer + NB_TOUT'(1);
                end
            end
            default: begin
                w_state_nxt = c_st_idle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_rst) begin
            r_state     <= c_st_idle;
            r_timer     <= '0;
            r_dato_a    <= '0;
            r_dato_b    <= '0;
            r_operation <= '0;
            r_tx_data   <= '0;
            r_valid     <= 1'b0;
            r_tx_start  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_timer    <= w_timer_nxt;
            r_valid    <= (w_state_nxt == c_st_exec);
            r_tx_start <= (w_state_nxt == c_st_send);
            r_busy     <= (w_state_nxt != c_st_idle);
            if (w_ld_a)   r_dato_a    <= i_rx_data;
            if (w_ld_b)   r_dato_b    <= i_rx_data;
            if (w_ld_op)  r_operation <= i_rx_data[NB_OP-1:0];
            if (w_ld_err) r_tx_data   <= ERR_BYTE;
            if (w_ld_res) r_tx_data   <= i_result;
        end
    end

    sat_counter #(.NB_CNT(NB_CNT)) u_err_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (w_err_inc),
        .o_cnt (o_err_cnt)
    );

    sat_counter #(.NB_CNT(NB_CNT)) u_tout_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (w_tout_inc),
        .o_cnt (o_tout_cnt)
    );

    sat_counter #(.NB_CNT(NB_CNT)) u_drop_cnt (
        .clk   (clk),
        .i_rst (i_rst),
        .i_inc (w_drop_inc),
        .o_cnt (o_drop_cnt)
    );

    assign o_tx_start  = r_tx_start;
    assign o_tx_data   = r_tx_data;
    assign o_datoA     = r_dato_a;
    assign o_datoB     = r_dato_b;
    assign o_operation = r_operation;
    assign o_valid     = r_valid;
    assign o_busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_alu_sequencer
//  Description : Randomized self-checking bench for uart_alu_sequencer with a
//                frame-level reference model and a behavioural ALU.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_sequencer;

    localparam int c_tout = 16;

    logic       clk = 1'b0;
    logic       i_rst;
    logic [7:0] i_rx_data;
    logic       i_rx_done;
    logic       i_tx_done;
    logic       o_tx_start;
    logic [7:0] o_tx_data;
    logic [7:0] o_datoA;
    logic [7:0] o_datoB;
    logic [5:0] o_operation;
    logic       o_valid;
    logic [7:0] i_result;
    logic       o_busy;
    logic [7:0] o_err_cnt;
    logic [7:0] o_tout_cnt;
    logic [7:0] o_drop_cnt;

    int n_tests = 0;
    int n_fail  = 0;
    int m_err   = 0;
    int m_tout  = 0;
    int m_drop  = 0;

    logic [5:0] legal_ops [8] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h27, 6'h03, 6'h02};

    always #5 clk = ~clk;

    uart_alu_sequencer #(
        .NB_DATA     (8),
        .NB_OP       (6),
        .NB_TOUT     (20),
        .TIMEOUT_CYC (c_tout),
        .NB_CNT      (8),
        .ERR_BYTE    (8'hFF)
    ) dut (
        .clk         (clk),
        .i_rst       (i_rst),
        .i_rx_data   (i_rx_data),
        .i_rx_done   (i_rx_done),
        .i_tx_done   (i_tx_done),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_datoA     (o_datoA),
        .o_datoB     (o_datoB),
        .o_operation (o_operation),
        .o_valid     (o_valid),
        .i_result    (i_result),
        .o_busy      (o_busy),
        .o_err_cnt   (o_err_cnt),
        .o_tout_cnt  (o_tout_cnt),
        .o_drop_cnt  (o_drop_cnt)
    );

    function automatic logic [7:0] alu(input logic [7:0] a, input logic [7:0] b, input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            6'h24:   return a & b;
            6'h25:   return a | b;
            6'h26:   return a ^ b;
            6'h27:   return ~(a | b);
            6'h03:   return $signed(a) >>> b;
            6'h02:   return a >> b;
            default: return 8'h00;
        endcase
    endfunction

    function automatic bit legal(input logic [5:0] op);
        foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int sat(input int v);
        return (v > 255) ? 255 : v;
    endfunction

    assign i_result = alu(o_datoA, o_datoB, o_operation);

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic send(input logic [7:0] b);
        i_rx_data = b;
        i_rx_done = 1'b1;
        tick();
        i_rx_done = 1'b0;
    endtask

    task automatic chk_cnts(input string tag);
        chk({tag, "_err"},  32'(o_err_cnt),  32'(m_err));
        chk({tag, "_tout"}, 32'(o_tout_cnt), 32'(m_tout));
        chk({tag, "_drop"}, 32'(o_drop_cnt), 32'(m_drop));
    endtask

    // tx_mode 0: tx_done after w WAIT_TX cycles (w <= c_tout-1); 1: no tx_done.
    task automatic do_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] opb,
                            input int gap1, input int gap2, input int tx_mode,
                            input int w, input bit drop, input bit full_chk);
        logic [5:0] op;
        op = opb[5:0];
        send(a);
        if (full_chk) chk("busy_get_b", 32'(o_busy), 32'd1);
        idle(gap1);
        send(b);
        idle(gap2);
        send(opb);
        if (legal(op)) begin
            if (full_chk) begin
                chk("valid_n1", 32'(o_valid), 32'd1);
                chk("dato_a",   32'(o_datoA), 32'(a));
                chk("dato_b",   32'(o_datoB), 32'(b));
                chk("oper",     32'(o_operation), 32'(op));
                chk("start_n1", 32'(o_tx_start), 32'd0);
            end
            tick();
            if (full_chk) chk("valid_n2", 32'(o_valid), 32'd0);
            chk("start_n2", 32'(o_tx_start), 32'd1);
            chk("tx_res",   32'(o_tx_data), 32'(alu(a, b, op)));
        end else begin
            m_err = sat(m_err + 1);
            if (full_chk) chk("valid_ill", 32'(o_valid), 32'd0);
            chk("start_ill", 32'(o_tx_start), 32'd1);
            chk("tx_err",    32'(o_tx_data), 32'hFF);
            chk("err_cnt",   32'(o_err_cnt), 32'(m_err));
        end
        tick();
        if (full_chk) chk("start_pulse", 32'(o_tx_start), 32'd0);
        if (tx_mode == 0) begin
            for (int i = 0; i < w; i++) begin
                if (drop && i == 0) begin
                    i_rx_data = 8'hAA;
                    i_rx_done = 1'b1;
                    m_drop    = sat(m_drop + 1);
                end
                tick();
                i_rx_done = 1'b0;
            end
            if (full_chk) chk("busy_wait", 32'(o_busy), 32'd1);
            i_tx_done = 1'b1;
            tick();
            i_tx_done = 1'b0;
            chk("busy_done", 32'(o_busy), 32'd0);
        end else begin
            idle(c_tout - 1);
            chk("busy_pre_tout", 32'(o_busy), 32'd1);
            tick();
            m_tout = sat(m_tout + 1);
            chk("busy_tout", 32'(o_busy), 32'd0);
        end
        if (full_chk) chk_cnts("frame");
    endtask

    function automatic logic [7:0] rand_op(input bit want_legal);
        logic [7:0] v;
        if (want_legal) begin
            v = {2'($urandom_range(0, 3)), legal_ops[$urandom_range(0, 7)]};
        end else begin
            do v = 8'($urandom); while (legal(v[5:0]));
        end
        return v;
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst     = 1'b1;
        i_rx_data = 8'h00;
        i_rx_done = 1'b0;
        i_tx_done = 1'b0;
        idle(3);
        i_rst = 1'b0;
        chk("rst_busy",  32'(o_busy), 32'd0);
        chk("rst_valid", 32'(o_valid), 32'd0);
        chk("rst_start", 32'(o_tx_start), 32'd0);
        chk("rst_txd",   32'(o_tx_data), 32'd0);
        chk("rst_op",    32'(o_operation), 32'd0);
        chk_cnts("rst");

        // Directed: ADD, illegal opcode
        do_frame(8'h05, 8'h03, 8'h20, 0, 0, 0, 3, 0, 1);
        do_frame(8'h10, 8'h22, 8'h3F, 0, 0, 0, 2, 0, 1);

        // Inter-byte timeout then a normal frame
        send(8'h07);
        idle(c_tout - 1);
        chk("tout_pre", 32'(o_busy), 32'd1);
        tick();
        m_tout = sat(m_tout + 1);
        chk("tout_idle", 32'(o_busy), 32'd0);
        chk_cnts("tout");
        do_frame(8'h01, 8'h01, 8'h20, 0, 0, 0, 1, 0, 1);

        // Drop during WAIT_TX, then normal frame
        do_frame(8'h33, 8'h11, 8'h22, 1, 1, 0, 4, 1, 1);
        do_frame(8'h0C, 8'h0A, 8'h26, 0, 0, 0, 1, 0, 1);

        // tx_done outside WAIT_TX is ignored
        i_tx_done = 1'b1;
        tick();
        i_tx_done = 1'b0;
        chk("txdone_idle", 32'(o_busy), 32'd0);

        // Reset in GET_OP
        send(8'h44);
        send(8'h55);
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        m_err = 0; m_tout = 0; m_drop = 0;
        chk("rst2_busy", 32'(o_busy), 32'd0);
        chk("rst2_a",    32'(o_datoA), 32'd0);
        chk_cnts("rst2");
        do_frame(8'hF0, 8'h0F, 8'h24, 0, 0, 0, 2, 0, 1);

        // Opcode on the expiry cycle; tx_done on the WAIT_TX expiry cycle
        do_frame(8'h09, 8'h04, 8'h22, 0, c_tout - 1, 0, c_tout - 1, 0, 1);
        do_frame(8'h81, 8'h02, 8'h03, c_tout - 1, 0, 1, 0, 0, 1);

        // Randomized frames
        for (int k = 0; k < 40; k++) begin
            do_frame(8'($urandom), 8'($urandom), rand_op($urandom_range(0, 9) < 7),
                     $urandom_range(0, c_tout - 1), $urandom_range(0, c_tout - 1),
                     ($urandom_range(0, 7) == 0) ? 1 : 0,
                     $urandom_range(1, c_tout - 1), 1'($urandom_range(0, 1)), 1);
        end

        // Error counter saturation
        for (int k = 0; k < 300; k++) begin
            do_frame(8'($urandom), 8'($urandom), rand_op(1'b0), 0, 0, 0, 0, 0, 0);
        end
        chk("err_sat", 32'(o_err_cnt), 32'd255);
        chk_cnts("final");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_alu_sequencer.md
Name: uart_alu_sequencer

Overview:
Command sequencer between UART_RX/UART_TX and the combinational ALU. It collects a fixed 3-byte frame (datoA, datoB, opcode) from the receiver and checks the opcode. It then strobes the ALU for one cycle, captures the result and sends it as one byte through the transmitter. It blocks new frames until the TX handshake completes, with inter-byte and TX timeouts.

Parameters:
NB_DATA, 8, data/operand/result width
NB_OP, 6, opcode width
NB_TOUT, 20, timeout counter width
TIMEOUT_CYC, 1000000, cycles without progress before abort (must be < 2**NB_TOUT)
NB_CNT, 8, width of saturating status counters
ERR_BYTE, 8'hFF, byte transmitted for an illegal opcode

Ports:
clk  in  1  system clock
i_rst  in  1  synchronous reset, active-high
i_rx_data  in  NB_DATA  byte from UART_RX, valid when i_rx_done=1
i_rx_done  in  1  one-cycle pulse, byte received
i_tx_done  in  1  one-cycle pulse, UART_TX finished the byte
o_tx_start  out  1  one-cycle pulse, start transmission
o_tx_data  out  NB_DATA  byte to transmit, stable from o_tx_start until i_tx_done
o_datoA  out  NB_DATA  ALU operand A
o_datoB  out  NB_DATA  ALU operand B
o_operation  out  NB_OP  ALU opcode
o_valid  out  1  one-cycle ALU strobe
i_result  in  NB_DATA  ALU result, combinational from operands/opcode
o_busy  out  1  high in every state except IDLE
o_err_cnt  out  NB_CNT  illegal-opcode count, saturating
o_tout_cnt  out  NB_CNT  timeout-abort count, saturating
o_drop_cnt  out  NB_CNT  bytes received while not accepting, saturating

Behaviour:
- All outputs registered. Synchronous reset on rising clk when i_rst=1: state IDLE, every output and counter 0. Reset mid-frame or mid-TX aborts silently with no counter increments.
- States: IDLE, GET_B, GET_OP, EXEC, SEND, WAIT_TX.
- IDLE: i_rx_done -> latch datoA, go to GET_B, clear timer.
- GET_B: i_rx_done -> latch datoB, go to GET_OP, clear timer.
- GET_OP: i_rx_done -> latch opcode (i_rx_data[NB_OP-1:0]).
  - Legal opcode: go to EXEC.
  - Illegal opcode: load o_tx_data=ERR_BYTE, increment o_err_cnt, go to SEND; EXEC is skipped and o_valid never rises.
- EXEC (1 cycle): o_valid=1; operands/opcode stable. At the end of the cycle capture i_result into o_tx_data, go to SEND.
- SEND (1 cycle): o_tx_start=1, go to WAIT_TX, clear timer.
- WAIT_TX: i_tx_done -> IDLE.
- Latency: opcode i_rx_done at cycle N -> o_valid=1 at N+1 -> o_tx_start=1 at N+2. For an illegal opcode, o_tx_start=1 at N+1.
- Timer counts in GET_B, GET_OP and WAIT_TX; it is held at 0 elsewhere.
  - Reaching TIMEOUT_CYC-1 -> IDLE, o_tout_cnt+1, partial frame discarded.
  - i_rx_done in the same cycle as expiry in GET_*: the byte wins and the timer clears.
  - i_tx_done in the same cycle as expiry in WAIT_TX: done wins, no timeout counted.
- i_rx_done in EXEC, SEND or WAIT_TX: byte discarded, o_drop_cnt+1.
- i_tx_done outside WAIT_TX: ignored.
- Operands and opcode registers hold their last values after the frame. Only o_valid and o_tx_start are pulses.
- Counters saturate at 2**NB_CNT-1; no wrap.
- Legal opcodes: ADD 6'b100000, SUB 6'b100010, AND 6'b100100, OR 6'b100101, XOR 6'b100110, NOR 6'b100111, SRA 6'b000011, SRL 6'b000010.

Decomposition:
- Shared package alu_pkg:
  - NB_DATA/NB_OP defaults
  - the eight opcode localparams
  - ERR_BYTE
  - state encoding (one-hot, 6 bits)
- Sub-module sat_counter (width parameter, inc, clear via i_rst), instantiated three times.
- Opcode legality check is a function in alu_pkg.

Test Plan:
1. Bytes 0x05, 0x03, 0x20 → o_valid pulse with A=0x05, B=0x03, op=0x20 at N+1. Bench ALU returns 0x08; o_tx_start at N+2 with o_tx_data=0x08. i_tx_done → IDLE, o_busy=0.
2. Bytes 0x10, 0x22, 0x3F (illegal) → no o_valid; o_tx_start at N+1 with 0xFF; o_err_cnt=1.
3. Byte 0x07, then idle for TIMEOUT_CYC (bench uses TIMEOUT_CYC=16) → IDLE, o_tout_cnt=1. Next frame 0x01, 0x01, 0x20 → result 0x02.
4. Extra byte 0xAA injected during WAIT_TX → o_drop_cnt=1, state unchanged. Next full frame is processed normally.
5. Reset asserted in GET_OP → all outputs 0, no counter change. Frame 0xF0, 0x0F, 0x24 → o_tx_data=0x00 (AND).
6. Opcode byte arrives on the exact timeout-expiry cycle → frame accepted, o_valid next cycle, o_tout_cnt unchanged. 300 illegal frames → o_err_cnt saturates at 255.
